uart_tx_device: RTL
===================

// Module: uart_tx_device
// PURPOSE
//  Memory-mapped bus responder (device side of the req/rvalid data bus) that accepts bytes from the core.
//  Bytes are buffered in a TX FIFO and serialised onto a UART line as 8N1, LSB first.
//  Occupies one 1 kB device slot on the system bus next to RAM and timer.
//  Provides a TX-empty interrupt.
// PARAMETERS
//  DataWidth     32      bus data width; only 32 supported
//  AddressWidth  32      bus address width; decode uses addr[9:2]
//  FifoDepth     16      TX FIFO entries; power of 2, >=2
//  ClkDivReset   433     reset value of CLKDIV; bit period = CLKDIV+1 clk cycles
// PORTS
//  clk_i           in   1      system clock
//  rst_i           in   1      asynchronous reset, active-high
//  dev_req_i       in   1      bus request (already granted by bus)
//  dev_we_i        in   1      1=write, 0=read
//  dev_be_i        in   4      byte enables
//  dev_addr_i      in   AW     byte address; offset = addr[9:0]
//  dev_wdata_i     in   DW     write data
//  dev_rvalid_o    out  1      response valid, reads and writes
//  dev_rdata_o     out  DW     read data, valid with rvalid
//  dev_err_o       out  1      error response, valid with rvalid
//  tx_o            out  1      serial line, idle high
//  irq_o           out  1      level interrupt
// BEHAVIOUR
//  Reset (async, rst_i=1):
//   - rvalid=0, rdata=0, err=0, tx_o=1, irq_o=0.
//   - FIFO empty; FSM IDLE; CLKDIV=ClkDivReset; CTRL=0.
//   - Reset asserted mid-frame aborts the frame; tx_o returns high immediately.
//  Bus timing:
//   - Every req gets exactly one response: rvalid=1 the cycle after req, 1 cycle wide.
//   - Back-to-back req every cycle supported; no backpressure.
//   - rdata=0 and err=0 whenever rvalid=0.
//  Register map (offset addr[9:2]):
//   0x00 TXDATA  W: if be[0], push wdata[7:0]. R: returns 0.
//   0x04 STATUS  R: bit0 full, bit1 empty, bit2 busy (FSM!=IDLE), bits[15:8] FIFO level. W: ignored, err=0.
//   0x08 CLKDIV  RW: bits[15:0]; upper bits read 0. Honors be[1:0] per byte.
//   0x0C CTRL    RW: bit0 tx_en, bit1 irq_en; others read 0. Honors be[0].
//   Other offsets: err=1, rdata=0, no side effect.
//  FIFO:
//   - Push to TXDATA while full: byte dropped, err=1. This holds even if the FSM pops in the same cycle.
//   - Push and pop in the same cycle when not full: level unchanged, order preserved.
//   - Read and write pointers are log2(FifoDepth) bits and wrap naturally; level counter is log2(FifoDepth)+1 bits.
//  Serialiser FSM (IDLE, START, DATA, STOP):
//   - IDLE -> START when tx_en=1 and FIFO non-empty. Pops head into an 8-bit shifter; baud counter loads CLKDIV.
//   - START: tx_o=0 for CLKDIV+1 cycles, then DATA.
//   - DATA: tx_o=shift[0]; shift right every CLKDIV+1 cycles; after 8 bits -> STOP.
//   - STOP: tx_o=1 for CLKDIV+1 cycles. Then START if tx_en and non-empty (no idle gap), else IDLE.
//   - Baud counter counts down to 0, then reloads from current CLKDIV. A CLKDIV write mid-frame takes effect at the next bit boundary.
//   - CLKDIV=0 gives one cycle per bit.
//   - tx_en cleared mid-frame: current frame completes, FSM then stays IDLE. FIFO contents are retained.
//  irq_o:
//   - Registered: irq_o = irq_en & empty & (state==IDLE).
//   - Updates one cycle after its condition changes.
// TESTING
//  1. Reset: rst_i pulse mid-frame -> tx_o=1 next cycle; STATUS read = 0x0000_0002; CLKDIV read = 433.
//  2. CLKDIV=3, CTRL=1, write 0xA5 -> tx_o: 0 (4 clk); then bits 1,0,1,0,0,1,0,1 (4 clk each); then 1 (4 clk). Total frame 40 clk.
//  3. Write 17 bytes with tx_en=0, FifoDepth=16:
//     - First 16 writes: err=0. 17th: err=1.
//     - STATUS level=16, full=1.
//     - Set tx_en: 16 frames sent back-to-back, in order, with no idle gap.
//  4. Read offset 0x10 and 0x3FC -> rvalid next cycle with err=1, rdata=0. Writes there change no register.
//  5. CTRL=3, one byte, CLKDIV=0 -> irq_o=0 during frame; irq_o=1 one cycle after FSM returns to IDLE; CTRL=1 -> irq_o=0.
//  6. Write CLKDIV 3->7 during DATA bit 2 -> bit 2 lasts 4 clk; bit 3 onward lasts 8 clk.

Source files
------------

// File: rtl/uart_tx_device.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_device                                                  |
// | Purpose  : Bus-mapped UART transmitter: TX FIFO, 8N1 serialiser, TX-empty  |
// |            interrupt.                                                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_tx_device #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int FifoDepth    = 16,
  parameter int ClkDivReset  = 433
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dev_req_i,
  input  logic                    dev_we_i,
  input  logic [3:0]              dev_be_i,
  input  logic [AddressWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0]    dev_wdata_i,
  output logic                    dev_rvalid_o,
  output logic [DataWidth-1:0]    dev_rdata_o,
  output logic                    dev_err_o,
  output logic                    tx_o,
  output logic                    irq_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] FullLevel = LvlW'(FifoDepth);

  localparam logic [7:0] RegTxData = 8'd0;
  localparam logic [7:0] RegStatus = 8'd1;
  localparam logic [7:0] RegClkDiv = 8'd2;
  localparam logic [7:0] RegCtrl   = 8'd3;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                state_q, state_d;
  logic [15:0]           baud_q, baud_d;
  logic [7:0]            shift_q, shift_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic                  tx_q, tx_d;
  logic                  irq_q, irq_d;
  logic                  rvalid_q, rvalid_d;
  logic [DataWidth-1:0]  rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [15:0]           clkdiv_q, clkdiv_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic [7:0]            mem_q [FifoDepth];

  logic [7:0] reg_idx;
  logic       full, empty, push, pop, launch;
  logic [7:0] head;
  logic       unused_bits;

  assign reg_idx = dev_addr_i[9:2];
  assign full    = (level_q == FullLevel);
  assign empty   = (level_q == '0);
  assign head    = mem_q[rptr_q];
  // A full FIFO rejects the push even when the serialiser frees a slot this cycle.
  assign push    = dev_req_i & dev_we_i & (reg_idx == RegTxData) & dev_be_i[0] & ~full;
  assign launch  = ctrl_q[0] & ~empty;

  assign unused_bits = ^{dev_addr_i[AddressWidth-1:10], dev_addr_i[1:0],
                         dev_wdata_i[DataWidth-1:16], dev_be_i[3:2]};

  always_comb begin
    rvalid_d = dev_req_i;
    rdata_d  = '0;
    err_d    = 1'b0;
    clkdiv_d = clkdiv_q;
    ctrl_d   = ctrl_q;
    if (dev_req_i) begin
      case (reg_idx)
        RegTxData: err_d = dev_we_i & dev_be_i[0] & full;
        RegStatus: if (!dev_we_i) begin
          rdata_d[0]           = full;
          rdata_d[1]           = empty;
          rdata_d[2]           = (state_q != StIdle);
          rdata_d[8 +: LvlW]   = level_q;
        end
        RegClkDiv: if (dev_we_i) begin
          if (dev_be_i[0]) clkdiv_d[7:0]  = dev_wdata_i[7:0];
          if (dev_be_i[1]) clkdiv_d[15:8] = dev_wdata_i[15:8];
        end else begin
          rdata_d[15:0] = clkdiv_q;
        end
        RegCtrl: if (dev_we_i) begin
          if (dev_be_i[0]) ctrl_d = dev_wdata_i[1:0];
        end else begin
          rdata_d[1:0] = ctrl_q;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    pop      = 1'b0;
    case (state_q)
      StIdle: if (launch) begin
        pop     = 1'b1;
        shift_d = head;
        baud_d  = clkdiv_q;
        state_d = StStart;
      end
      StStart: if (baud_q == '0) begin
        baud_d   = clkdiv_q;
        bitcnt_d = '0;
        state_d  = StData;
      end else begin
        baud_d = baud_q - 16'd1;
      end
      StData: if (baud_q == '0) begin
        baud_d = clkdiv_q;
        if (bitcnt_q == 3'd7) begin
          state_d = StStop;
        end else begin
          shift_d  = {1'b0, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
        end
      end else begin
        baud_d = baud_q - 16'd1;
      end
      StStop: if (baud_q == '0) begin
        // Chain straight into the next start bit when more data is queued.
        if (launch) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = clkdiv_q;
          state_d = StStart;
        end else begin
          state_d = StIdle;
        end
      end else begin
        baud_d = baud_q - 16'd1;
      end
      default: state_d = StIdle;
    endcase

    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    irq_d = ctrl_q[1] & empty & (state_q == StIdle);
  end

  always_comb begin
    wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PtrW'(1) : rptr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= dev_wdata_i[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      clkdiv_q <= 16'(ClkDivReset);
      ctrl_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      clkdiv_q <= clkdiv_d;
      ctrl_q   <= ctrl_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
    end
  end

  assign dev_rvalid_o = rvalid_q;
  assign dev_rdata_o  = rdata_q;
  assign dev_err_o    = err_q;
  assign tx_o         = tx_q;
  assign irq_o        = irq_q;

endmodule
`default_nettype wire
